// File: rtl/turn_sequencer.sv
// Per-turn controller for the four-in-a-row game: times the player's turn, validates
// player/PC column requests, tracks column heights and issues one board write per turn.
module turn_sequencer #(
  parameter int TICKS_PER_SEC = 50_000_000,
  parameter int TURN_SECS     = 10,
  parameter int COLS          = 7,
  parameter int ROWS          = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            playState,
  input  logic            pcState,
  input  logic            playerValid,
  input  logic [2:0]      playerCol,
  input  logic            pcValid,
  input  logic [2:0]      pcCol,
  output logic            timeExpired,
  output logic            playerMov,
  output logic            pcMov,
  output logic            moveReject,
  output logic            wrEn,
  output logic [2:0]      wrRow,
  output logic [2:0]      wrCol,
  output logic            wrPlayer,
  output logic [3:0]      secondsLeft,
  output logic [COLS-1:0] colFull,
  output logic            boardFull
);

  localparam int              PW        = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0]   PRESC_MAX = PW'(TICKS_PER_SEC - 1);
  localparam logic [3:0]      COLS_W    = 4'(COLS);
  localparam logic [2:0]      ROWS_W    = 3'(ROWS);
  localparam logic [3:0]      SECS_W    = 4'(TURN_SECS);

  typedef enum logic [2:0] {IDLE, P_TURN, P_DONE, C_TURN, C_DONE} state_t;

  state_t          state, state_next;
  logic [PW-1:0]   prescaler, presc_next;
  logic [3:0]      secs_next;
  logic [2:0]      height      [8];
  logic [2:0]      height_next [8];
  logic [7:0]      full_pad;
  logic            p_ok, c_ok, tick;
  logic            wr_next, wr_player_next, p_mov_next, c_mov_next, rej_next, texp_next;
  logic [2:0]      wr_row_next, wr_col_next;
  logic [COLS-1:0] col_full_next;

  // Columns beyond COLS read as not full; the range check rejects them anyway.
  assign full_pad = 8'(colFull);
  assign p_ok     = ({1'b0, playerCol} < COLS_W) && !full_pad[playerCol];
  assign c_ok     = ({1'b0, pcCol} < COLS_W) && !full_pad[pcCol];

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_next     = state;
    presc_next     = prescaler;
    secs_next      = secondsLeft;
    height_next    = height;
    wr_next        = 1'b0;
    wr_row_next    = wrRow;
    wr_col_next    = wrCol;
    wr_player_next = wrPlayer;
    p_mov_next     = 1'b0;
    c_mov_next     = 1'b0;
    rej_next       = 1'b0;
    texp_next      = 1'b0;
    tick           = 1'b0;

    case (state)
      IDLE: begin
        if (playState) begin
          state_next = P_TURN;
          secs_next  = SECS_W;
          presc_next = '0;
        end else if (pcState) begin
          state_next = C_TURN;
        end
      end
      P_TURN: begin
        if (!playState) begin
          state_next = IDLE;
        end else if (playerValid && p_ok) begin
          // An accepted move pre-empts a same-edge timer expiry.
          wr_next                = 1'b1;
          wr_row_next            = height[playerCol];
          wr_col_next            = playerCol;
          wr_player_next         = 1'b1;
          p_mov_next             = 1'b1;
          height_next[playerCol] = height[playerCol] + 3'd1;
          state_next             = P_DONE;
        end else begin
          rej_next = playerValid;
          tick     = 1'b1;
        end
      end
      P_DONE: if (!playState) state_next = IDLE;
      C_TURN: begin
        if (!pcState) begin
          state_next = IDLE;
        end else if (pcValid && c_ok) begin
          wr_next            = 1'b1;
          wr_row_next        = height[pcCol];
          wr_col_next        = pcCol;
          wr_player_next     = 1'b0;
          c_mov_next         = 1'b1;
          height_next[pcCol] = height[pcCol] + 3'd1;
          state_next         = C_DONE;
        end else begin
          rej_next = pcValid;
        end
      end
      C_DONE: if (!pcState) state_next = IDLE;
      default: state_next = IDLE;
    endcase

    if (tick) begin
      if (prescaler == PRESC_MAX) begin
        presc_next = '0;
        if (secondsLeft != 4'd0) begin
          secs_next = secondsLeft - 4'd1;
          if (secondsLeft == 4'd1) begin
            texp_next  = 1'b1;
            state_next = P_DONE;
          end
        end
      end else begin
        presc_next = prescaler + PW'(1);
      end
    end

    for (int c = 0; c < COLS; c++) col_full_next[c] = (height_next[c] == ROWS_W);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      prescaler   <= '0;
      secondsLeft <= '0;
      // NOTE: the height table is board state, so it is cleared by reset like any register.
      for (int c = 0; c < 8; c++) height[c] <= '0;
      wrEn        <= 1'b0;
      wrRow       <= '0;
      wrCol       <= '0;
      wrPlayer    <= 1'b0;
      playerMov   <= 1'b0;
      pcMov       <= 1'b0;
      moveReject  <= 1'b0;
      timeExpired <= 1'b0;
      colFull     <= '0;
      boardFull   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      state       <= state_next;
      prescaler   <= presc_next;
      secondsLeft <= secs_next;
      height      <= height_next;
      wrEn        <= wr_next;
      wrRow       <= wr_row_next;
      wrCol       <= wr_col_next;
      wrPlayer    <= wr_player_next;
      playerMov   <= p_mov_next;
      pcMov       <= c_mov_next;
      moveReject  <= rej_next;
      timeExpired <= texp_next;
      colFull     <= col_full_next;
      boardFull   <= &col_full_next;
    end
  end

endmodule
